// File: rtl/register_file.sv
// 2R/1W general-purpose register file; r0 hardwired to zero, combinational reads
// with an optional same-cycle write-to-read bypass on each read port.

module register_file_rd #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic [ADDR_W-1:0]                     addr,
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]    regs,
  input  logic                                  rst,
  input  logic                                  wr_en,
  input  logic [ADDR_W-1:0]                     wr_addr,
  input  logic [DATA_W-1:0]                     wr_data,
  output logic [DATA_W-1:0]                     rd_data
);
  logic hit;

  // Bypass is suppressed during reset so reads reflect the stored contents.
  assign hit = (BYPASS != 0) && wr_en && !rst && (wr_addr == addr);

  always_comb begin
    rd_data = regs[addr];
    if (addr == '0)
      rd_data = '0;
    else if (hit)
      rd_data = wr_data;
  end
endmodule

module register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NPORTS = 2;

  logic [DEPTH-1:0][DATA_W-1:0]  regs;
  logic [NPORTS-1:0][ADDR_W-1:0] rd_addr;
  logic [NPORTS-1:0][DATA_W-1:0] rd_data;

  // Reset wins over a concurrent write; r0 is never written.
  always_ff @(posedge clk) begin
    if (rst)
      regs <= '0;
    else if (wr_en && (wr_addr != '0))
      regs[wr_addr] <= wr_data;
  end

  assign rd_addr = {rt_addr, rs_addr};

  for (genvar p = 0; p < NPORTS; p++) begin : g_rd
    register_file_rd #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS)
    ) u_rd (
      .addr    (rd_addr[p]),
      .regs    (regs),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_data (rd_data[p])
    );
  end

  assign rs_data = rd_data[0];
  assign rt_data = rd_data[1];
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench: a bypassing and a non-bypassing instance share stimulus
// and are checked against an array model of the register file.

module tb_register_file;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs_addr, rt_addr, wr_addr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [31:0] rs_b, rt_b, rs_n, rt_n;

  logic [31:0] model [32];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_b), .rt_data(rt_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_nob (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_n), .rt_data(rt_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // Expected read value from the architectural rules and the current inputs.
  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 0) return 32'h0;
    if (byp && wr_en && !rst && wr_addr == a) return wr_data;
    return model[a];
  endfunction

  // Advance one clock; the model commits what the register file should have.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (wr_en && wr_addr != 0) begin
      model[wr_addr] = wr_data;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
  endtask

  task automatic test_reset();
    rst = 1; wr_en = 0; wr_addr = 0; wr_data = 0; rs_addr = 0; rt_addr = 0;
    step();
    idle();
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    step();
    idle(); rs_addr = 5; #1;
    n_cmp++;
    if (rs_b !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL reset_prewrite: got %h want %h", rs_b, 32'hDEADBEEF);
    end
    rst = 1;
    step();
    rst = 0; #1;
    n_cmp++;
    if (rs_b !== 32'h0 || rs_n !== 32'h0) begin
      n_err++; $display("FAIL reset_r5: got %h/%h want 0", rs_b, rs_n);
    end
    for (int a = 0; a < 32; a++) begin
      rs_addr = a[4:0]; rt_addr = a[4:0]; #1;
      n_cmp++;
      if (rs_b !== 0 || rt_b !== 0 || rs_n !== 0 || rt_n !== 0) begin
        n_err++;
        $display("FAIL reset_all[%0d]: got %h %h %h %h want 0", a, rs_b, rt_b, rs_n, rt_n);
      end
    end
  endtask

  task automatic test_basic();
    idle(); wr_en = 1; wr_addr = 7; wr_data = 32'h12345678;
    step();
    wr_addr = 31; wr_data = 32'hFFFFFFFF;
    step();
    idle(); rs_addr = 7; rt_addr = 31; #1;
    n_cmp++;
    if (rs_b !== 32'h12345678 || rs_n !== 32'h12345678) begin
      n_err++; $display("FAIL basic_r7: got %h/%h want 12345678", rs_b, rs_n);
    end
    n_cmp++;
    if (rt_b !== 32'hFFFFFFFF || rt_n !== 32'hFFFFFFFF) begin
      n_err++; $display("FAIL basic_r31: got %h/%h want ffffffff", rt_b, rt_n);
    end
  endtask

  task automatic test_zero();
    idle(); wr_en = 1; wr_addr = 0; wr_data = 32'hA5A5A5A5; rs_addr = 0; rt_addr = 0; #1;
    n_cmp++;
    if (rs_b !== 0 || rt_b !== 0 || rs_n !== 0 || rt_n !== 0) begin
      n_err++; $display("FAIL zero_during: got %h %h %h %h want 0", rs_b, rt_b, rs_n, rt_n);
    end
    step();
    idle(); #1;
    n_cmp++;
    if (rs_b !== 0 || rt_b !== 0 || rs_n !== 0 || rt_n !== 0) begin
      n_err++; $display("FAIL zero_after: got %h %h %h %h want 0", rs_b, rt_b, rs_n, rt_n);
    end
  endtask

  task automatic test_bypass();
    idle(); wr_en = 1; wr_addr = 3; wr_data = 32'h11;
    step();
    wr_data = 32'h22; rs_addr = 3; rt_addr = 3; #1;
    n_cmp++;
    if (rs_b !== 32'h22 || rt_b !== 32'h22) begin
      n_err++; $display("FAIL bypass_on: got %h %h want 00000022", rs_b, rt_b);
    end
    n_cmp++;
    if (rs_n !== 32'h11 || rt_n !== 32'h11) begin
      n_err++; $display("FAIL bypass_off: got %h %h want 00000011", rs_n, rt_n);
    end
    step();
    idle(); #1;
    n_cmp++;
    if (rs_b !== 32'h22 || rt_b !== 32'h22 || rs_n !== 32'h22 || rt_n !== 32'h22) begin
      n_err++; $display("FAIL bypass_next: got %h %h %h %h want 00000022", rs_b, rt_b, rs_n, rt_n);
    end
  endtask

  task automatic test_wr_disable();
    idle(); wr_addr = 4; wr_data = 32'h1; rs_addr = 4; rt_addr = 7;
    step();
    #1;
    n_cmp++;
    if (rs_b !== 0 || rs_n !== 0) begin
      n_err++; $display("FAIL wr_disable: got %h/%h want 0", rs_b, rs_n);
    end
    rst = 1; wr_en = 1; wr_addr = 4; wr_data = 32'hCAFEF00D; #1;
    n_cmp++;
    if (rs_b !== 0) begin
      n_err++; $display("FAIL rst_no_bypass: got %h want 0", rs_b);
    end
    n_cmp++;
    if (rt_b !== 32'h12345678) begin
      n_err++; $display("FAIL rst_stored: got %h want 12345678", rt_b);
    end
    step();
    idle(); #1;
    n_cmp++;
    if (rs_b !== 0 || rs_n !== 0) begin
      n_err++; $display("FAIL rst_collision: got %h/%h want 0", rs_b, rs_n);
    end
    n_cmp++;
    if (rt_b !== 0 || rt_n !== 0) begin
      n_err++; $display("FAIL rst_clear_r7: got %h/%h want 0", rt_b, rt_n);
    end
  endtask

  task automatic test_random();
    logic [31:0] e;
    for (int c = 0; c < 10000; c++) begin
      rst     = ($urandom_range(63) == 0);
      wr_en   = $urandom_range(1);
      wr_addr = 5'($urandom_range(31));
      wr_data = $urandom;
      rs_addr = ($urandom_range(3) == 0) ? wr_addr : 5'($urandom_range(31));
      rt_addr = ($urandom_range(3) == 0) ? wr_addr : 5'($urandom_range(31));
      #1;
      e = exp_rd(rs_addr, 1'b1); n_cmp++;
      if (rs_b !== e) begin n_err++; $display("FAIL rand_rs_byp c%0d: got %h want %h", c, rs_b, e); end
      e = exp_rd(rt_addr, 1'b1); n_cmp++;
      if (rt_b !== e) begin n_err++; $display("FAIL rand_rt_byp c%0d: got %h want %h", c, rt_b, e); end
      e = exp_rd(rs_addr, 1'b0); n_cmp++;
      if (rs_n !== e) begin n_err++; $display("FAIL rand_rs_nob c%0d: got %h want %h", c, rs_n, e); end
      e = exp_rd(rt_addr, 1'b0); n_cmp++;
      if (rt_n !== e) begin n_err++; $display("FAIL rand_rt_nob c%0d: got %h want %h", c, rt_n, e); end
      step();
    end
  endtask

  initial begin
    rst = 1; wr_en = 0; wr_addr = 0; wr_data = 0; rs_addr = 0; rt_addr = 0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_zero();
    test_bypass();
    test_wr_disable();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
